// File: rtl/mem_arbiter.sv
// Byte-wide memory port shared by instruction fetch and the load/store buffer.
// Multi-byte accesses are split into per-byte bus cycles, little-endian.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_SEL = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_req,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_size,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE,
        IF_READ,
        LSB_READ,
        LSB_WRITE
    } state_e;

    state_e            state_q;
    logic [2:0]        idx_q;
    logic [2:0]        n_q;
    logic              v_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;
    logic              last_lsb_q;
    logic              if_done_q;
    logic              lsb_done_q;
    logic [31:0]       if_data_q;
    logic [31:0]       lsb_rdata_q;

    logic        rd_busy;
    logic        io_stall;
    logic [2:0]  rd_ptr;
    logic [2:0]  a_off;
    logic        issue_ok;
    logic        last_byte;
    logic        if_ok;
    logic        lsb_ok;
    logic        grant_if;
    logic        grant_lsb;
    logic [2:0]  n_d;
    logic [31:0] buf_d;

    assign rd_busy  = (state_q == IF_READ) || (state_q == LSB_READ);
    assign io_stall = (addr_q[17:16] == IO_SEL) && io_buffer_full;

    // v_q: mem_din this cycle carries byte idx_q; idx_q counts bytes done.
    assign rd_ptr    = idx_q + {2'b00, v_q};
    assign issue_ok  = rd_ptr < n_q;
    assign last_byte = v_q && (idx_q == n_q - 3'd1);

    // While paused, keep requesting the first byte not yet captured.
    assign a_off = (rd_busy && rdy_in) ? rd_ptr : idx_q;

    // A requester's held req is ignored during its own done cycle.
    assign if_ok     = if_req && !if_done_q;
    assign lsb_ok    = lsb_req && !lsb_done_q;
    assign grant_lsb = lsb_ok && (!if_ok || !last_lsb_q);
    assign grant_if  = if_ok && !grant_lsb;

    always_comb begin
        unique case (lsb_size)
            2'd0:    n_d = 3'd1;
            2'd1:    n_d = 3'd2;
            default: n_d = 3'd4;
        endcase
    end

    always_comb begin
        buf_d = buf_q;
        buf_d[{idx_q[1:0], 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        unique case (state_q)
            IDLE: begin
            end
            IF_READ, LSB_READ: begin
                mem_a = addr_q + {{(ADDR_W-3){1'b0}}, a_off};
            end
            LSB_WRITE: begin
                mem_a    = addr_q + {{(ADDR_W-3){1'b0}}, a_off};
                mem_dout = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy_in && !io_stall;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            v_q         <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            last_lsb_q  <= 1'b0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            if_data_q   <= '0;
            lsb_rdata_q <= '0;
        end else begin
            if_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
            if (!rdy_in) begin
                if (rd_busy) v_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (!flush && (grant_if || grant_lsb)) begin
                            idx_q <= '0;
                            v_q   <= 1'b0;
                            buf_q <= '0;
                            if (grant_lsb) begin
                                last_lsb_q <= 1'b1;
                                addr_q     <= lsb_addr;
                                wdata_q    <= lsb_wdata;
                                n_q        <= n_d;
                                state_q    <= lsb_wr ? LSB_WRITE : LSB_READ;
                            end else begin
                                last_lsb_q <= 1'b0;
                                addr_q     <= if_addr;
                                n_q        <= 3'd4;
                                state_q    <= IF_READ;
                            end
                        end
                    end
                    IF_READ, LSB_READ: begin
                        if (flush) begin
                            state_q <= IDLE;
                        end else begin
                            if (v_q) begin
                                buf_q <= buf_d;
                                idx_q <= idx_q + 3'd1;
                            end
                            v_q <= issue_ok;
                            if (last_byte) begin
                                state_q <= IDLE;
                                if (state_q == IF_READ) begin
                                    if_done_q <= 1'b1;
                                    if_data_q <= buf_d;
                                end else begin
                                    lsb_done_q  <= 1'b1;
                                    lsb_rdata_q <= buf_d;
                                end
                            end
                        end
                    end
                    LSB_WRITE: begin
                        if (!io_stall) begin
                            idx_q <= idx_q + 3'd1;
                            if (idx_q == n_q - 3'd1) begin
                                state_q    <= IDLE;
                                lsb_done_q <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency byte RAM model.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int ncmp = 0;
    int nerr = 0;
    int log_base;

    logic [7:0]  ram   [0:65535];
    bit          wflag [0:65535];
    logic [23:0] wlog  [$];

    always #5 clk_in = ~clk_in;

    mem_arbiter dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush          (flush),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .lsb_req        (lsb_req),
        .lsb_wr         (lsb_wr),
        .lsb_size       (lsb_size),
        .lsb_addr       (lsb_addr),
        .lsb_wdata      (lsb_wdata),
        .lsb_done       (lsb_done),
        .lsb_rdata      (lsb_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            32'h200: return 8'h5A;
            32'h201: return 8'h77;
            32'h300: return 8'hEF;
            32'h301: return 8'hBE;
            32'h302: return 8'h99;
            32'h400: return 8'h01;
            32'h401: return 8'h02;
            32'h402: return 8'h03;
            32'h403: return 8'h04;
            32'h500: return 8'hA1;
            32'h501: return 8'hB2;
            32'h502: return 8'hC3;
            32'h503: return 8'hD4;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] peek(input logic [31:0] a);
        return wflag[a[15:0]] ? ram[a[15:0]] : init_byte(a);
    endfunction

    always @(posedge clk_in) begin
        mem_din <= peek(mem_a);
        if (mem_wr) begin
            ram[mem_a[15:0]]   <= mem_dout;
            wflag[mem_a[15:0]] <= 1'b1;
            wlog.push_back({mem_a[15:0], mem_dout});
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic lsb_set(input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        lsb_req   = 1'b1;
        lsb_wr    = wr;
        lsb_size  = sz;
        lsb_addr  = a;
        lsb_wdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = '0;
        lsb_addr = '0; lsb_wdata = '0; io_buffer_full = 1'b0;
        step(); step();
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_dout", mem_dout, 8'h0);
        chk("rst_if_done", if_done, 1'b0);
        chk("rst_lsb_done", lsb_done, 1'b0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_lsb_rdata", lsb_rdata, 32'h0);
        rst_in = 1'b1;
        step();

        // IF-only word fetch
        if_req = 1'b1; if_addr = 32'h100;
        step(); chk("if_a0", mem_a, 32'h100); chk("if_wr0", mem_wr, 1'b0);
        step(); chk("if_a1", mem_a, 32'h101);
        step(); chk("if_a2", mem_a, 32'h102);
        step(); chk("if_a3", mem_a, 32'h103);
        step(); chk("if_busy", if_done, 1'b0);
        step(); chk("if_done", if_done, 1'b1);
        chk("if_data", if_data, 32'h44332211);
        if_req = 1'b0;
        step(); chk("if_pulse", if_done, 1'b0);

        // byte store
        lsb_set(1'b1, 2'd0, 32'h200, 32'hAABBCCDD);
        step(); chk("st_a", mem_a, 32'h200);
        chk("st_dout", mem_dout, 8'hDD); chk("st_wr", mem_wr, 1'b1);
        step(); chk("st_done", lsb_done, 1'b1); chk("st_wr_off", mem_wr, 1'b0);
        chk("st_ram200", peek(32'h200), 8'hDD);
        chk("st_ram201", peek(32'h201), 8'h77);
        lsb_req = 1'b0;
        step(); chk("st_pulse", lsb_done, 1'b0);

        // simultaneous requests after reset
        rst_in = 1'b0; step(); rst_in = 1'b1;
        if_req = 1'b1; if_addr = 32'h400;
        lsb_set(1'b0, 2'd1, 32'h300, 32'h0);
        step(); chk("tie_lsb_first", mem_a, 32'h300);
        step(); chk("tie_a1", mem_a, 32'h301);
        step(); chk("tie_busy", lsb_done, 1'b0);
        step(); chk("tie_ld_done", lsb_done, 1'b1);
        chk("tie_ld_half", lsb_rdata, 32'h0000BEEF);
        chk("tie_no_if", if_done, 1'b0);
        lsb_req = 1'b0;
        step(); chk("tie_if_next", mem_a, 32'h400);
        repeat (4) step();
        step(); chk("tie_if_done", if_done, 1'b1);
        chk("tie_if_data", if_data, 32'h04030201);
        if_req = 1'b0;
        step();
        if_req = 1'b1; if_addr = 32'h100;
        lsb_set(1'b0, 2'd0, 32'h200, 32'h0);
        step(); chk("no_if_twice", mem_a, 32'h200);
        step();
        step(); chk("rr_ld_done", lsb_done, 1'b1);
        chk("rr_ld_byte", lsb_rdata, 32'h000000DD);
        lsb_req = 1'b0;
        step(); chk("rr_if_grant", mem_a, 32'h100);
        repeat (4) step();
        step(); chk("rr_if_done", if_done, 1'b1);
        chk("rr_if_data", if_data, 32'h44332211);
        if_req = 1'b0;
        step();

        // IO store with buffer-full stall
        log_base = wlog.size();
        lsb_set(1'b1, 2'd2, 32'h30000, 32'h87654321);
        step(); chk("io_a0", mem_a, 32'h30000);
        chk("io_d0", mem_dout, 8'h21); chk("io_wr0", mem_wr, 1'b1);
        step(); io_buffer_full = 1'b1; #1; chk("io_stall1", mem_wr, 1'b0);
        step(); chk("io_stall2", mem_wr, 1'b0);
        step(); chk("io_stall3", mem_wr, 1'b0);
        step(); io_buffer_full = 1'b0; #1;
        chk("io_wr1", mem_wr, 1'b1); chk("io_a1", mem_a, 32'h30001);
        chk("io_d1", mem_dout, 8'h43);
        step(); chk("io_a2", mem_a, 32'h30002); chk("io_d2", mem_dout, 8'h65);
        step(); chk("io_a3", mem_a, 32'h30003); chk("io_d3", mem_dout, 8'h87);
        chk("io_not_yet", lsb_done, 1'b0);
        step(); chk("io_done", lsb_done, 1'b1);
        chk("io_nwrites", wlog.size() - log_base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("io_log", (log_base + i < wlog.size()) ? wlog[log_base + i] : 24'hFFFFFF,
                {16'(i), 8'(32'h87654321 >> (8 * i))});
        end
        lsb_req = 1'b0;
        step(); chk("io_pulse", lsb_done, 1'b0);

        // flush during IF read, pending LSB load
        if_req = 1'b1; if_addr = 32'h100;
        step();
        step(); lsb_set(1'b0, 2'd0, 32'h201, 32'h0);
        step(); flush = 1'b1;
        step(); flush = 1'b0;
        chk("fl_no_done", if_done, 1'b0); chk("fl_idle", mem_a, 32'h0);
        if_req = 1'b0;
        step(); chk("fl_lsb_grant", mem_a, 32'h201);
        step();
        step(); chk("fl_ld_done", lsb_done, 1'b1);
        chk("fl_ld_data", lsb_rdata, 32'h00000077);
        chk("fl_if_quiet", if_done, 1'b0);
        lsb_req = 1'b0;
        step();

        // flush in IDLE blocks the grant; flush during a store is ignored
        flush = 1'b1; io_buffer_full = 1'b1;
        lsb_set(1'b1, 2'd1, 32'h210, 32'h00001234);
        step(); chk("fi_no_grant_wr", mem_wr, 1'b0); chk("fi_no_grant_a", mem_a, 32'h0);
        flush = 1'b0;
        step(); chk("fs_a0", mem_a, 32'h210); chk("fs_wr0", mem_wr, 1'b1);
        chk("fs_d0", mem_dout, 8'h34);
        flush = 1'b1;
        step(); chk("fs_a1", mem_a, 32'h211); chk("fs_d1", mem_dout, 8'h12);
        chk("fs_wr1", mem_wr, 1'b1);
        flush = 1'b0; io_buffer_full = 1'b0;
        step(); chk("fs_done", lsb_done, 1'b1);
        chk("fs_ram210", peek(32'h210), 8'h34);
        chk("fs_ram211", peek(32'h211), 8'h12);
        lsb_req = 1'b0;
        step();

        // asynchronous reset in the middle of a store
        lsb_set(1'b1, 2'd2, 32'h220, 32'hDEADBEEF);
        step();
        step(); chk("rs_pre_wr", mem_wr, 1'b1);
        rst_in = 1'b0; #1;
        chk("rs_async_wr", mem_wr, 1'b0); chk("rs_async_a", mem_a, 32'h0);
        lsb_req = 1'b0;
        step(); rst_in = 1'b1;
        step(); chk("rs_idle_wr", mem_wr, 1'b0); chk("rs_idle_a", mem_a, 32'h0);
        chk("rs_no_done", lsb_done, 1'b0);

        // two-cycle pause in the middle of a fetch
        if_req = 1'b1; if_addr = 32'h500;
        step(); chk("pz_a0", mem_a, 32'h500);
        step();
        step(); rdy_in = 1'b0; #1; chk("pz_redrive", mem_a, 32'h501);
        step();
        step(); rdy_in = 1'b1;
        step();
        step(); chk("pz_not_yet", if_done, 1'b0);
        step(); chk("pz_done", if_done, 1'b1);
        chk("pz_data", if_data, 32'hD4C3B2A1);
        if_req = 1'b0;
        step(); chk("pz_pulse", if_done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
